// File: rtl/proc_control_fsm.sv
// proc_control_fsm: step-counter control unit for the base processor.
// A single 2-bit step register (T0..T3) drives a combinational decoder that
// produces the per-cycle datapath strobes from the current step and the IR.
module proc_control_fsm #(
    parameter int REG_ADDR_W = 3,
    parameter int OPC_W      = 3,
    localparam int NUM_REGS  = 2 ** REG_ADDR_W,
    localparam int IR_W      = OPC_W + 2 * REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  run,
    input  logic [IR_W-1:0]       ir,
    input  logic                  g_zero,
    output logic                  ir_en,
    output logic [NUM_REGS-1:0]   rin,
    output logic [REG_ADDR_W-1:0] rout,
    output logic                  din_en,
    output logic                  gout,
    output logic                  ain,
    output logic                  gin,
    output logic [1:0]            alu_op,
    output logic                  done,
    output logic                  illegal,
    output logic [1:0]            step
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [OPC_W-1:0] OPC_MV   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_MVI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_MVNZ = OPC_W'(5);

    step_t step_reg;
    step_t step_next;

    logic [OPC_W-1:0]      opc;
    logic [REG_ADDR_W-1:0] rx;
    logic [REG_ADDR_W-1:0] ry;
    logic                  is_alu;

    // Register write is decoded from an enable plus address so the one-hot
    // vector scales with the register-file size.
    logic                  rin_we;
    logic [REG_ADDR_W-1:0] rin_addr;

    assign opc    = ir[IR_W-1:2*REG_ADDR_W];
    assign rx     = ir[2*REG_ADDR_W-1:REG_ADDR_W];
    assign ry     = ir[REG_ADDR_W-1:0];
    assign is_alu = (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND);

    // Step register: the only state in the block.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            step_reg <= T0;
        end else begin
            step_reg <= step_next;
        end
    end

    // Next-step and strobe decode; everything stays 0 while reset is low.
    always_comb begin
        step_next = T0;
        ir_en     = 1'b0;
        rin_we    = 1'b0;
        rin_addr  = '0;
        rout      = '0;
        din_en    = 1'b0;
        gout      = 1'b0;
        ain       = 1'b0;
        gin       = 1'b0;
        alu_op    = 2'b00;
        done      = 1'b0;
        illegal   = 1'b0;

        if (resetn) begin
            case (step_reg)
                T0: begin
                    ir_en     = run;
                    step_next = run ? T1 : T0;
                end
                T1: begin
                    if (opc == OPC_MV) begin
                        rout     = ry;
                        rin_we   = 1'b1;
                        rin_addr = rx;
                        done     = 1'b1;
                    end else if (opc == OPC_MVI) begin
                        din_en   = 1'b1;
                        rin_we   = 1'b1;
                        rin_addr = rx;
                        done     = 1'b1;
                    end else if (is_alu) begin
                        rout      = rx;
                        ain       = 1'b1;
                        step_next = T2;
                    end else if (opc == OPC_MVNZ) begin
                        // Move only when G is non-zero; the instruction ends
                        // in this cycle either way.
                        if (!g_zero) begin
                            rout     = ry;
                            rin_we   = 1'b1;
                            rin_addr = rx;
                        end
                        done = 1'b1;
                    end else begin
                        // Every opcode from 6 upward is reserved.
                        illegal = 1'b1;
                        done    = 1'b1;
                    end
                end
                T2: begin
                    if (is_alu) begin
                        rout      = ry;
                        gin       = 1'b1;
                        step_next = T3;
                        if (opc == OPC_SUB) begin
                            alu_op = 2'b01;
                        end else if (opc == OPC_AND) begin
                            alu_op = 2'b10;
                        end else begin
                            alu_op = 2'b00;
                        end
                    end
                end
                T3: begin
                    if (is_alu) begin
                        gout     = 1'b1;
                        rin_we   = 1'b1;
                        rin_addr = rx;
                        done     = 1'b1;
                    end
                end
                default: begin
                    step_next = T0;
                end
            endcase
        end
    end

    // One-hot register write enable.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rin
            assign rin[gi] = rin_we && (rin_addr == REG_ADDR_W'(gi));
        end
    endgenerate

    assign step = resetn ? step_reg : 2'b00;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Testbench for proc_control_fsm: per-cycle expected strobes are queued as
// stimulus is driven and compared at the following falling edge.
module tb_proc_control_fsm;

    typedef struct packed {
        logic [1:0] step;
        logic       ir_en;
        logic [7:0] rin;
        logic [2:0] rout;
        logic       din_en;
        logic       gout;
        logic       ain;
        logic       gin;
        logic [1:0] alu_op;
        logic       done;
        logic       illegal;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic       run;
    logic [8:0] ir;
    logic       g_zero;
    logic       ir_en;
    logic [7:0] rin;
    logic [2:0] rout;
    logic       din_en;
    logic       gout;
    logic       ain;
    logic       gin;
    logic [1:0] alu_op;
    logic       done;
    logic       illegal;
    logic [1:0] step;

    // Wider register file instance
    logic        resetn2;
    logic        run2;
    logic [10:0] ir2;
    logic        g_zero2;
    logic        ir_en2;
    logic [15:0] rin2;
    logic [3:0]  rout2;
    logic        din_en2;
    logic        gout2;
    logic        ain2;
    logic        gin2;
    logic [1:0]  alu_op2;
    logic        done2;
    logic        illegal2;
    logic [1:0]  step2;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    exp_t sb_q[$];

    proc_control_fsm #(.REG_ADDR_W(3), .OPC_W(3)) dut (
        .clock(clock), .resetn(resetn), .run(run), .ir(ir), .g_zero(g_zero),
        .ir_en(ir_en), .rin(rin), .rout(rout), .din_en(din_en), .gout(gout),
        .ain(ain), .gin(gin), .alu_op(alu_op), .done(done), .illegal(illegal),
        .step(step)
    );

    proc_control_fsm #(.REG_ADDR_W(4), .OPC_W(3)) dut_w (
        .clock(clock), .resetn(resetn2), .run(run2), .ir(ir2), .g_zero(g_zero2),
        .ir_en(ir_en2), .rin(rin2), .rout(rout2), .din_en(din_en2), .gout(gout2),
        .ain(ain2), .gin(gin2), .alu_op(alu_op2), .done(done2), .illegal(illegal2),
        .step(step2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(int st, int ie, int ri, int ro, int de, int go,
                                int ai, int gn, int al, int dn, int il);
        exp_t e;
        e.step    = 2'(st);
        e.ir_en   = 1'(ie);
        e.rin     = 8'(ri);
        e.rout    = 3'(ro);
        e.din_en  = 1'(de);
        e.gout    = 1'(go);
        e.ain     = 1'(ai);
        e.gin     = 1'(gn);
        e.alu_op  = 2'(al);
        e.done    = 1'(dn);
        e.illegal = 1'(il);
        return e;
    endfunction

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        check_eq("step",    32'(step),    32'(e.step));
        check_eq("ir_en",   32'(ir_en),   32'(e.ir_en));
        check_eq("rin",     32'(rin),     32'(e.rin));
        check_eq("rout",    32'(rout),    32'(e.rout));
        check_eq("din_en",  32'(din_en),  32'(e.din_en));
        check_eq("gout",    32'(gout),    32'(e.gout));
        check_eq("ain",     32'(ain),     32'(e.ain));
        check_eq("gin",     32'(gin),     32'(e.gin));
        check_eq("alu_op",  32'(alu_op),  32'(e.alu_op));
        check_eq("done",    32'(done),    32'(e.done));
        check_eq("illegal", 32'(illegal), 32'(e.illegal));
        $display("cyc %0d: rstn=%0b run=%0b ir=%03h gz=%0b -> step=%0d ir_en=%0b rin=%02h rout=%0d ain=%0b gin=%0b gout=%0b alu=%0d done=%0b ill=%0b",
                 ncyc, resetn, run, ir, g_zero, step, ir_en, rin, rout, ain, gin, gout, alu_op, done, illegal);
        ncyc++;
    endtask

    // Drive one cycle of inputs, queue its expectation, compare at negedge.
    task automatic cyc(input logic r_n, input logic rn, input logic [8:0] i,
                       input logic gz, input exp_t e);
        @(posedge clock);
        #1;
        resetn = r_n;
        run    = rn;
        ir     = i;
        g_zero = gz;
        sb_q.push_back(e);
        @(negedge clock);
        compare_out();
    endtask

    initial begin
        resetn  = 1'b0;
        run     = 1'b0;
        ir      = 9'h000;
        g_zero  = 1'b0;
        resetn2 = 1'b0;
        run2    = 1'b0;
        ir2     = 11'h000;
        g_zero2 = 1'b0;

        // Reset state, with run high to prove it is masked
        cyc(1'b0, 1'b1, 9'h00A, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));
        cyc(1'b0, 1'b0, 9'h00A, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));

        // mv r1,r2
        cyc(1'b1, 1'b1, 9'h00A, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h00A, 1'b0, mk(1,0,8'h02,2,0,0,0,0,0,1,0));
        cyc(1'b1, 1'b0, 9'h00A, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));

        // add r3,r4 then and r3,r4 back-to-back with run held high
        cyc(1'b1, 1'b1, 9'h09C, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b1, 9'h09C, 1'b0, mk(1,0,0,3,0,0,1,0,0,0,0));
        cyc(1'b1, 1'b1, 9'h09C, 1'b0, mk(2,0,0,4,0,0,0,1,0,0,0));
        cyc(1'b1, 1'b1, 9'h09C, 1'b0, mk(3,0,8'h08,0,0,1,0,0,0,1,0));
        cyc(1'b1, 1'b1, 9'h11C, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b1, 9'h11C, 1'b0, mk(1,0,0,3,0,0,1,0,0,0,0));
        cyc(1'b1, 1'b1, 9'h11C, 1'b0, mk(2,0,0,4,0,0,0,1,2,0,0));
        cyc(1'b1, 1'b1, 9'h11C, 1'b0, mk(3,0,8'h08,0,0,1,0,0,0,1,0));

        // sub r3,r4 with run dropped in T2; then idle in T0
        cyc(1'b1, 1'b1, 9'h0DC, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b1, 9'h0DC, 1'b0, mk(1,0,0,3,0,0,1,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h0DC, 1'b0, mk(2,0,0,4,0,0,0,1,1,0,0));
        cyc(1'b1, 1'b0, 9'h0DC, 1'b0, mk(3,0,8'h08,0,0,1,0,0,0,1,0));
        cyc(1'b1, 1'b0, 9'h0DC, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h0DC, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));

        // mvnz r5,r6 with G non-zero, then with G zero
        cyc(1'b1, 1'b1, 9'h16E, 1'b1, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h16E, 1'b0, mk(1,0,8'h20,6,0,0,0,0,0,1,0));
        cyc(1'b1, 1'b1, 9'h16E, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h16E, 1'b1, mk(1,0,0,0,0,0,0,0,0,1,0));

        // mvi r2
        cyc(1'b1, 1'b1, 9'h050, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h050, 1'b0, mk(1,0,8'h04,0,1,0,0,0,0,1,0));

        // Reserved opcodes 110 and 111
        cyc(1'b1, 1'b1, 9'h180, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b1, 9'h180, 1'b0, mk(1,0,0,0,0,0,0,0,0,1,1));
        cyc(1'b1, 1'b1, 9'h1FF, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h1FF, 1'b0, mk(1,0,0,0,0,0,0,0,0,1,1));
        cyc(1'b1, 1'b0, 9'h1FF, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));

        // Reset applied in T2 of add: outputs forced low, then back in T0
        cyc(1'b1, 1'b1, 9'h09C, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h09C, 1'b0, mk(1,0,0,3,0,0,1,0,0,0,0));
        cyc(1'b0, 1'b0, 9'h09C, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h09C, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));
        cyc(1'b1, 1'b0, 9'h09C, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0));

        // 16-register instance: mv r9,r12
        check_eq("w_rst_rin", 32'(rin2), 32'h0);
        check_eq("w_rst_step", 32'(step2), 32'h0);
        @(posedge clock);
        #1;
        resetn2 = 1'b1;
        run2    = 1'b1;
        ir2     = 11'h09C;
        @(negedge clock);
        check_eq("w_t0_ir_en", 32'(ir_en2), 32'h1);
        check_eq("w_t0_step", 32'(step2), 32'h0);
        $display("wide cyc T0: ir_en=%0b step=%0d", ir_en2, step2);
        @(posedge clock);
        #1;
        run2 = 1'b0;
        @(negedge clock);
        check_eq("w_t1_rin", 32'(rin2), 32'h0200);
        check_eq("w_t1_rout", 32'(rout2), 32'd12);
        check_eq("w_t1_done", 32'(done2), 32'h1);
        check_eq("w_t1_step", 32'(step2), 32'h1);
        $display("wide cyc T1: rin=%04h rout=%0d done=%0b", rin2, rout2, done2);
        @(posedge clock);
        #1;
        @(negedge clock);
        check_eq("w_t0b_step", 32'(step2), 32'h0);
        check_eq("w_t0b_rin", 32'(rin2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
